// File: rtl/rs232_rx_oversampler_if.sv
// Bundles the serial line, error clear and received-byte outputs of rs232_rx_oversampler.
// The master side drives the line; the slave side is the receiver.
interface rs232_rx_oversampler_if;
    logic       Rxd;
    logic       ClearError;
    logic [7:0] DataOut1;
    logic [7:0] DataOut2;
    logic       RxValid;
    logic       Busy;
    logic       FrameError;
    logic       ParityError;

    modport master (
        output Rxd, ClearError,
        input  DataOut1, DataOut2, RxValid, Busy, FrameError, ParityError
    );

    modport slave (
        input  Rxd, ClearError,
        output DataOut1, DataOut2, RxValid, Busy, FrameError, ParityError
    );
endinterface

// File: rtl/rs232_rx_oversampler.sv
// 16x-oversampled 8N1 RS232 receiver keeping the last two bytes, with sticky error flags.
// Define RS232_RX_PARITY_EN to insert an even-parity bit between data and stop.
module rs232_rx_oversampler #(
    parameter int CLK_DIV     = 326,
    parameter int SYNC_STAGES = 2
) (
    input logic                   SystemClock,
    input logic                   Reset,
    rs232_rx_oversampler_if.slave rxBus
);

`ifdef RS232_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rxState_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rxState_t;
`endif

    localparam logic [9:0] DivLast = 10'(CLK_DIV - 1);

    rxState_t               state, stateNext;
    logic [SYNC_STAGES-1:0] syncReg;
    logic                   rxs;
    logic [9:0]             divCount;
    logic                   tick;
    logic [3:0]             scnt, scntNext;
    logic [2:0]             bitCnt, bitCntNext;
    logic [7:0]             shiftReg, shiftNext;
    logic [7:0]             dataOut1, dataOut2;
    logic                   rxValid;
    logic                   frameError;
    logic                   acceptByte;
    logic                   setFrame;
`ifdef RS232_RX_PARITY_EN
    logic                   parityBad, parityBadNext;
    logic                   parityError;
    logic                   setParity;
`endif

    assign rxs  = syncReg[SYNC_STAGES-1];
    assign tick = (divCount == DivLast);

    // Next-state logic; everything advances only on sample ticks.
    always_comb begin
        stateNext  = state;
        scntNext   = scnt;
        bitCntNext = bitCnt;
        shiftNext  = shiftReg;
        acceptByte = 1'b0;
        setFrame   = 1'b0;
`ifdef RS232_RX_PARITY_EN
        parityBadNext = parityBad;
        setParity     = 1'b0;
`endif
        if (tick) begin
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        stateNext = START;
                        scntNext  = 4'd0;
                    end
                end
                START: begin
                    if (scnt == 4'd7) begin
                        scntNext   = 4'd0;
                        bitCntNext = 3'd0;
                        stateNext  = rxs ? IDLE : DATA;
                    end else begin
                        scntNext = scnt + 4'd1;
                    end
                end
                DATA: begin
                    scntNext = scnt + 4'd1;
                    if (scnt == 4'd15) begin
                        shiftNext  = {rxs, shiftReg[7:1]};
                        bitCntNext = bitCnt + 3'd1;
                        if (bitCnt == 3'd7) begin
`ifdef RS232_RX_PARITY_EN
                            stateNext = PARITY;
`else
                            stateNext = STOP;
`endif
                        end
                    end
                end
`ifdef RS232_RX_PARITY_EN
                PARITY: begin
                    scntNext = scnt + 4'd1;
                    if (scnt == 4'd15) begin
                        parityBadNext = (^shiftReg) ^ rxs;
                        setParity     = parityBadNext;
                        stateNext     = STOP;
                    end
                end
`endif
                STOP: begin
                    scntNext = scnt + 4'd1;
                    if (scnt == 4'd15) begin
                        if (rxs) begin
`ifdef RS232_RX_PARITY_EN
                            acceptByte = !parityBad;
`else
                            acceptByte = 1'b1;
`endif
                            stateNext  = IDLE;
                        end else begin
                            setFrame  = 1'b1;
                            stateNext = BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rxs) stateNext = IDLE;
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    // Registers: synchroniser, free-running divider, FSM, byte history and sticky flags.
    always_ff @(posedge SystemClock) begin
        if (Reset) begin
            syncReg    <= '1;
            divCount   <= '0;
            state      <= IDLE;
            scnt       <= '0;
            bitCnt     <= '0;
            shiftReg   <= '0;
            dataOut1   <= '0;
            dataOut2   <= '0;
            rxValid    <= 1'b0;
            frameError <= 1'b0;
`ifdef RS232_RX_PARITY_EN
            parityBad   <= 1'b0;
            parityError <= 1'b0;
`endif
        end else begin
            syncReg    <= {syncReg[SYNC_STAGES-2:0], rxBus.Rxd};
            divCount   <= tick ? 10'd0 : divCount + 10'd1;
            state      <= stateNext;
            scnt       <= scntNext;
            bitCnt     <= bitCntNext;
            shiftReg   <= shiftNext;
            rxValid    <= acceptByte;
            frameError <= setFrame | (frameError & ~rxBus.ClearError);
            if (acceptByte) begin
                dataOut2 <= dataOut1;
                dataOut1 <= shiftReg;
            end
`ifdef RS232_RX_PARITY_EN
            parityBad   <= parityBadNext;
            parityError <= setParity | (parityError & ~rxBus.ClearError);
`endif
        end
    end

    assign rxBus.DataOut1   = dataOut1;
    assign rxBus.DataOut2   = dataOut2;
    assign rxBus.RxValid    = rxValid;
    assign rxBus.Busy       = (state != IDLE);
    assign rxBus.FrameError = frameError;
`ifdef RS232_RX_PARITY_EN
    assign rxBus.ParityError = parityError;
`else
    assign rxBus.ParityError = 1'b0;
`endif

endmodule
